// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges ID load-use stalls with
// EX multi-cycle op holds, and flushes/redirects the PC on exceptions.
module pipe_stall_ctrl #(
  parameter int CNT_W  = 6,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_id,
  input  logic              ex_mc_start,
  input  logic [CNT_W-1:0]  ex_mc_len,
  input  logic              exc_req,
  input  logic [ADDR_W-1:0] exc_vec,
  output logic [5:0]        stall,
  output logic              flush,
  output logic [ADDR_W-1:0] new_pc,
  output logic              ex_mc_busy,
  output logic              ex_mc_done,
  output logic              ex_mc_abort
);

  localparam logic [5:0] HAZ = 6'b000111;
  localparam logic [5:0] MCS = 6'b001111;

  typedef enum logic {IDLE, MC} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    stall       = '0;
    flush       = 1'b0;
    new_pc      = '0;
    ex_mc_busy  = 1'b0;
    ex_mc_done  = 1'b0;
    ex_mc_abort = 1'b0;
    if (rst) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else if (exc_req) begin
      // Exception wins over everything; an in-flight op is cancelled.
      flush       = 1'b1;
      new_pc      = exc_vec;
      ex_mc_abort = (state == MC);
      state_nxt   = IDLE;
      cnt_nxt     = '0;
    end else begin
      case (state)
        IDLE: begin
          if (ex_mc_start && ex_mc_len >= CNT_W'(2)) begin
            // Start cycle is the first of N-1 held cycles.
            stall      = MCS;
            ex_mc_busy = 1'b1;
            cnt_nxt    = ex_mc_len - CNT_W'(2);
            state_nxt  = MC;
          end else begin
            stall = stallreq_id ? HAZ : 6'b000000;
          end
        end
        MC: begin
          if (cnt != '0) begin
            stall      = MCS;
            ex_mc_busy = 1'b1;
            cnt_nxt    = cnt - CNT_W'(1);
          end else begin
            // Done cycle: a new start here is ignored; legal next cycle.
            ex_mc_done = 1'b1;
            stall      = stallreq_id ? HAZ : 6'b000000;
            state_nxt  = IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: per-cycle vector table plus a few
// hand-written multi-cycle sequences, checked through an expected-result queue.
module tb_pipe_stall_ctrl;
  localparam int CNT_W  = 6;
  localparam int ADDR_W = 32;
  localparam logic [5:0] HAZ = 6'b000111;
  localparam logic [5:0] MCS = 6'b001111;
  localparam logic [5:0] NON = 6'b000000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              stallreq_id = 1'b0;
  logic              ex_mc_start = 1'b0;
  logic [CNT_W-1:0]  ex_mc_len = '0;
  logic              exc_req = 1'b0;
  logic [ADDR_W-1:0] exc_vec = '0;
  logic [5:0]        stall;
  logic              flush;
  logic [ADDR_W-1:0] new_pc;
  logic              ex_mc_busy, ex_mc_done, ex_mc_abort;

  pipe_stall_ctrl #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .ex_mc_start(ex_mc_start),
    .ex_mc_len(ex_mc_len), .exc_req(exc_req), .exc_vec(exc_vec), .stall(stall),
    .flush(flush), .new_pc(new_pc), .ex_mc_busy(ex_mc_busy),
    .ex_mc_done(ex_mc_done), .ex_mc_abort(ex_mc_abort)
  );

  always #5 clk = ~clk;

  typedef struct {
    string             name;
    logic              rst, sr, st;
    logic [CNT_W-1:0]  len;
    logic              exc;
    logic [ADDR_W-1:0] vec;
    logic [5:0]        e_stall;
    logic              e_flush;
    logic [ADDR_W-1:0] e_pc;
    logic              e_busy, e_done, e_abort;
  } vec_t;

  typedef struct {
    string       name;
    logic [41:0] exp;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input string nm, input logic r, sr, st,
                              input logic [CNT_W-1:0] ln, input logic ex,
                              input logic [ADDR_W-1:0] ev, input logic [5:0] es,
                              input logic ef, input logic [ADDR_W-1:0] ep,
                              input logic eb, ed, ea);
    vec_t v;
    v.name = nm; v.rst = r; v.sr = sr; v.st = st; v.len = ln; v.exc = ex; v.vec = ev;
    v.e_stall = es; v.e_flush = ef; v.e_pc = ep;
    v.e_busy = eb; v.e_done = ed; v.e_abort = ea;
    return v;
  endfunction

  // Drive one cycle at negedge, queue expectation, compare 2ns later.
  task automatic apply(input vec_t v);
    exp_t e, g;
    logic [41:0] got;
    @(negedge clk);
    rst = v.rst; stallreq_id = v.sr; ex_mc_start = v.st; ex_mc_len = v.len;
    exc_req = v.exc; exc_vec = v.vec;
    e.name = v.name;
    e.exp  = {v.e_stall, v.e_flush, v.e_pc, v.e_busy, v.e_done, v.e_abort};
    sb.push_back(e);
    #2;
    g = sb.pop_front();
    got = {stall, flush, new_pc, ex_mc_busy, ex_mc_done, ex_mc_abort};
    checks++;
    if (got !== g.exp) begin
      errors++;
      $display("FAIL %s: got stall=%b flush=%b pc=%h busy=%b done=%b abort=%b, expected stall=%b flush=%b pc=%h busy=%b done=%b abort=%b",
               g.name, got[41:36], got[35], got[34:3], got[2], got[1], got[0],
               g.exp[41:36], g.exp[35], g.exp[34:3], g.exp[2], g.exp[1], g.exp[0]);
    end
  endtask

  initial begin
    // Reset with all inputs high
    tbl.push_back(mk("rst0", 1,1,1,6'd5,1,32'h180, NON,0,0,0,0,0));
    tbl.push_back(mk("rst1", 1,1,1,6'd5,1,32'h180, NON,0,0,0,0,0));
    tbl.push_back(mk("rst_rel", 0,0,0,0,0,0, NON,0,0,0,0,0));
    // ID hazard 3 cycles
    for (int i = 0; i < 3; i++) tbl.push_back(mk("haz", 0,1,0,0,0,0, HAZ,0,0,0,0,0));
    tbl.push_back(mk("haz_end", 0,0,0,0,0,0, NON,0,0,0,0,0));
    // Div N=5
    tbl.push_back(mk("n5_start", 0,0,1,6'd5,0,0, MCS,0,0,1,0,0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk("n5_hold", 0,0,0,0,0,0, MCS,0,0,1,0,0));
    tbl.push_back(mk("n5_done", 0,0,0,0,0,0, NON,0,0,0,1,0));
    tbl.push_back(mk("n5_idle", 0,0,0,0,0,0, NON,0,0,0,0,0));
    // N=2
    tbl.push_back(mk("n2_start", 0,0,1,6'd2,0,0, MCS,0,0,1,0,0));
    tbl.push_back(mk("n2_done", 0,0,0,0,0,0, NON,0,0,0,1,0));
    // N=1 and N=0: single-cycle, no stall, no done
    tbl.push_back(mk("n1_start", 0,0,1,6'd1,0,0, NON,0,0,0,0,0));
    tbl.push_back(mk("n1_after", 0,0,0,0,0,0, NON,0,0,0,0,0));
    tbl.push_back(mk("n0_haz", 0,1,1,6'd0,0,0, HAZ,0,0,0,0,0));
    tbl.push_back(mk("n0_after", 0,0,0,0,0,0, NON,0,0,0,0,0));
    // Abort N=10 at t+3
    tbl.push_back(mk("ab_start", 0,0,1,6'd10,0,0, MCS,0,0,1,0,0));
    tbl.push_back(mk("ab_hold1", 0,0,0,0,0,0, MCS,0,0,1,0,0));
    tbl.push_back(mk("ab_hold2", 0,0,0,0,0,0, MCS,0,0,1,0,0));
    tbl.push_back(mk("ab_exc", 0,0,0,0,1,32'h0000_0180, NON,1,32'h0000_0180,0,0,1));
    for (int i = 0; i < 8; i++) tbl.push_back(mk("ab_after", 0,0,0,0,0,0, NON,0,0,0,0,0));
    // Exception in IDLE with start: no abort, start ignored
    tbl.push_back(mk("exc_idle", 0,1,1,6'd4,1,32'hdead_beef, NON,1,32'hdead_beef,0,0,0));
    tbl.push_back(mk("exc_idle_nx", 0,0,0,0,0,0, NON,0,0,0,0,0));
    // Overlap with ID hazard, N=4
    tbl.push_back(mk("ov_start", 0,1,1,6'd4,0,0, MCS,0,0,1,0,0));
    tbl.push_back(mk("ov_hold1", 0,1,0,0,0,0, MCS,0,0,1,0,0));
    tbl.push_back(mk("ov_hold2", 0,1,0,0,0,0, MCS,0,0,1,0,0));
    tbl.push_back(mk("ov_done", 0,1,0,0,0,0, HAZ,0,0,0,1,0));
    tbl.push_back(mk("ov_after", 0,0,0,0,0,0, NON,0,0,0,0,0));
    // Back-to-back N=3
    tbl.push_back(mk("bb_start", 0,0,1,6'd3,0,0, MCS,0,0,1,0,0));
    tbl.push_back(mk("bb_hold", 0,0,0,0,0,0, MCS,0,0,1,0,0));
    tbl.push_back(mk("bb_done_ign", 0,0,1,6'd3,0,0, NON,0,0,0,1,0));
    tbl.push_back(mk("bb_start2", 0,0,1,6'd3,0,0, MCS,0,0,1,0,0));
    tbl.push_back(mk("bb_hold2", 0,0,0,0,0,0, MCS,0,0,1,0,0));
    tbl.push_back(mk("bb_done2", 0,0,0,0,0,0, NON,0,0,0,1,0));
    tbl.push_back(mk("bb_after", 0,0,0,0,0,0, NON,0,0,0,0,0));

    foreach (tbl[i]) apply(tbl[i]);

    // Reset mid-op: no done, no abort afterwards
    apply(mk("rm_start", 0,0,1,6'd6,0,0, MCS,0,0,1,0,0));
    apply(mk("rm_hold", 0,0,0,0,0,0, MCS,0,0,1,0,0));
    apply(mk("rm_rst", 1,0,0,0,1,32'h40, NON,0,0,0,0,0));
    for (int i = 0; i < 5; i++) apply(mk("rm_after", 0,0,0,0,0,0, NON,0,0,0,0,0));

    // Exception in the done cycle still counts as MC: abort, no done
    apply(mk("xd_start", 0,0,1,6'd2,0,0, MCS,0,0,1,0,0));
    apply(mk("xd_exc", 0,0,0,0,1,32'h200, NON,1,32'h200,0,0,1));
    apply(mk("xd_after", 0,0,0,0,0,0, NON,0,0,0,0,0));

    // Maximum length op: N-1 held cycles then done
    apply(mk("max_start", 0,0,1,6'd63,0,0, MCS,0,0,1,0,0));
    for (int i = 0; i < 61; i++) apply(mk("max_hold", 0,0,0,0,0,0, MCS,0,0,1,0,0));
    apply(mk("max_done", 0,0,0,0,0,0, NON,0,0,0,1,0));
    apply(mk("max_after", 0,0,0,0,0,0, NON,0,0,0,0,0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
